adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//  Shares one five_bit_adder datapath between two requesters.
//  Round-robin arbitration per transaction; a multi-beat transaction holds the grant until its last beat.
//  Results go out through a one-entry registered result slot with a valid/ready handshake.
//  Sits between operand producers and the shared adder for multi-word (5-bit-chunk) additions.
// PARAMETERS
//  W          5  operand/sum width; must equal the instantiated adder width (5)
//  MAX_BEATS  8  maximum accepted beats per transaction before forced release (>=1)
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  req0_valid  in   1  requester 0 beat valid
//  req0_a      in   W  requester 0 operand A chunk
//  req0_b      in   W  requester 0 operand B chunk
//  req0_cin    in   1  requester 0 carry-in
//  req0_last   in   1  requester 0 final beat of transaction
//  req0_ready  out  1  requester 0 beat accepted when valid&ready
//  req1_*      same set as req0_* for requester 1
//  res_valid   out  1  result slot occupied
//  res_sum     out  W  registered sum chunk
//  res_cout    out  1  registered carry-out
//  res_id      out  1  requester that owns the result (0/1)
//  res_last    out  1  result is the final beat of its transaction
//  res_ready   in   1  consumer takes result when res_valid&res_ready
//  lock_err    out  1  one-cycle pulse: transaction force-released at MAX_BEATS
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, rr pointer favours req0, carry reg 0, beat count 0.
//    All outputs 0; a held result is discarded. Reset mid-transaction drops the lock.
//  - FSM states:
//    - IDLE: arbiter picks the winner combinationally. Single valid -> that requester; both valid ->
//      the requester not served last (req0 after reset). Only the winner sees ready.
//      An accepted non-last beat -> LOCKED(owner). An accepted last beat stays IDLE and flips rr.
//    - LOCKED(owner): only the owner may get ready; the other requester's ready=0.
//      Owner dropping valid does not release the lock; the timeout counts beats, not cycles.
//      Accepted last beat -> IDLE; rr points to the other requester.
//  - Slot free = !res_valid | res_ready. req_ready = granted & slot free.
//    Drain and accept in the same cycle are allowed: one beat per cycle sustained.
//  - Accepted beat: {cout,sum} = a + b + cin_eff in W+1 bits, through the shared adder (cin port honoured).
//    Registered into the slot: latency 1 cycle from acceptance to res_valid.
//    res_id = owner; res_last = req_last | forced.
//  - No accept and slot drained -> res_valid=0. res_* stay stable while res_valid & !res_ready.
//  - Beat counter: clog2(MAX_BEATS+1) bits, cleared at transaction start.
//    The MAX_BEATS-th accepted beat with last=0 is treated as last (forced).
//    Forced release: res_last=1, lock_err pulses the cycle res_valid rises, FSM -> IDLE, rr flips.
//    MAX_BEATS=1 makes every beat single-beat.
//  - Wrap: W-bit sum wraps modulo 2^W; overflow is reported only on res_cout.
// CONFIGURATION
//  CARRY_CHAIN_EN defined:
//    First beat of a transaction: cin_eff = req_cin.
//    Later beats: cin_eff = cout registered from the previous accepted beat of the same transaction.
//    Carry reg clears on transaction end and on reset.
//  CARRY_CHAIN_EN undefined: every beat uses cin_eff = req_cin; no carry reg.
// TESTING
//  1 req0 a=7 b=9 cin=0 last=1, res_ready=1 -> next cycle res_valid=1, sum=16, cout=0, id=0, last=1.
//  2 Both valid, single-beat ops back-to-back after reset -> grant/res_id order 0,1,0,1; no dead cycles.
//  3 req1 beat0 a=31 b=1 cin=0 last=0, beat1 a=0 b=0 cin=0 last=1; req0 valid throughout.
//    -> beat0 result sum=0 cout=1.
//    -> beat1 result sum=1 with CHAIN_EN, sum=0 without.
//    -> req0_ready=0 until beat1 accepted; req0 served next.
//  4 res_ready=0 with slot full -> both req_ready=0, res_* frozen 3 cycles.
//    res_ready=1 -> drain plus new accept in the same cycle.
//  5 req0 8 beats all last=0 (MAX_BEATS=8) -> 8th result res_last=1, lock_err=1 one cycle, req1 granted next.
//  6 rst_n=0 mid-LOCKED with res_valid=1 -> res_valid=0 at once.
//    After release, both valid -> req0 wins; carry reg=0.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one five_bit_adder.
// Optional CARRY_CHAIN_EN chains carry across beats of a transaction.

module five_bit_adder #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total;

  // W+1-bit add keeps the carry-out alongside the wrapped sum
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

  assign sum  = total[W-1:0];
  assign cout = total[W];

endmodule

module adder_share_arbiter #(
  parameter int W         = 5,
  parameter int MAX_BEATS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req0_last,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  input  logic         req1_last,
  output logic         req1_ready,
  output logic         res_valid,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_id,
  output logic         res_last,
  input  logic         res_ready,
  output logic         lock_err
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BEATS);
  localparam logic [CW-1:0] CONE = CW'(1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t        state;
  logic          owner;
  logic          rr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic          win;
  logic          sel;
  logic          g0;
  logic          g1;
  logic          slot_free;
  logic          acc;
  logic [W-1:0]  s_a;
  logic [W-1:0]  s_b;
  logic          s_cin;
  logic          s_last;
  logic          forced;
  logic          eff_last;
  logic          cin_eff;
  logic [W-1:0]  add_sum;
  logic          add_cout;

  // idle winner: lone requester, else the one not served last
  always_comb begin
    win = rr;
    unique case (1'b1)
      req0_valid & ~req1_valid: win = 1'b0;
      req1_valid & ~req0_valid: win = 1'b1;
      default:                  win = rr;
    endcase
  end

  assign sel = (state == LOCKED) ? owner : win;

  // grant: lock owner regardless of valid, else idle winner
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (1'b1)
      state == LOCKED: begin
        g0 = ~owner;
        g1 = owner;
      end
      default: begin
        g0 = req0_valid & ~win;
        g1 = req1_valid & win;
      end
    endcase
  end

  assign slot_free  = ~res_valid | res_ready;
  assign req0_ready = g0 & slot_free & rst_n;
  assign req1_ready = g1 & slot_free & rst_n;

  assign acc = (req0_valid & req0_ready)
             | (req1_valid & req1_ready);

  // mux the selected requester's beat onto the adder
  always_comb begin
    s_a    = req0_a;
    s_b    = req0_b;
    s_cin  = req0_cin;
    s_last = req0_last;
    if (sel) begin
      s_a    = req1_a;
      s_b    = req1_b;
      s_cin  = req1_cin;
      s_last = req1_last;
    end
  end

  assign cnt_nxt  = (state == IDLE) ? CONE : cnt + CONE;
  assign forced   = ~s_last & (cnt_nxt == CMAX);
  assign eff_last = s_last | forced;

`ifdef CARRY_CHAIN_EN
  logic carry;

  assign cin_eff = (state == IDLE) ? s_cin : carry;

  // carry links beats of one transaction, cleared at its end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (acc) begin
      carry <= eff_last ? 1'b0 : add_cout;
    end
  end
`else
  assign cin_eff = s_cin;
`endif

  five_bit_adder #(
    .W(W)
  ) u_add (
    .a   (s_a),
    .b   (s_b),
    .cin (cin_eff),
    .sum (add_sum),
    .cout(add_cout)
  );

  // arbitration fsm: lock on non-last beat, release and flip rr on last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      rr    <= 1'b0;
      cnt   <= '0;
    end else if (acc) begin
      if (eff_last) begin
        state <= IDLE;
        rr    <= ~sel;
        cnt   <= '0;
      end else begin
        state <= LOCKED;
        owner <= sel;
        cnt   <= cnt_nxt;
      end
    end
  end

  // one-entry result slot, loads on accept, empties on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= 1'b0;
      res_last  <= 1'b0;
      lock_err  <= 1'b0;
    end else begin
      lock_err <= acc & forced;
      if (acc) begin
        res_valid <= 1'b1;
        res_sum   <= add_sum;
        res_cout  <= add_cout;
        res_id    <= sel;
        res_last  <= eff_last;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed tests for adder_share_arbiter.
// Expected values are hand-computed per scenario.

module tb_adder_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_cin, req0_last, req0_ready;
  logic [4:0] req0_a, req0_b;
  logic       req1_valid, req1_cin, req1_last, req1_ready;
  logic [4:0] req1_a, req1_b;
  logic       res_valid, res_cout, res_id, res_last, res_ready;
  logic [4:0] res_sum;
  logic       lock_err;

  int checks = 0;
  int errors = 0;

  // {valid,id,last,cout,sum}
  logic [8:0] rv;
  logic [1:0] rdy;
  assign rv  = {res_valid, res_id, res_last, res_cout, res_sum};
  assign rdy = {req0_ready, req1_ready};

  adder_share_arbiter #(
    .W(5),
    .MAX_BEATS(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_cin  (req0_cin),
    .req0_last (req0_last),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_cin  (req1_cin),
    .req1_last (req1_last),
    .req1_ready(req1_ready),
    .res_valid (res_valid),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .res_last  (res_last),
    .res_ready (res_ready),
    .lock_err  (lock_err)
  );

  always #5 clk = ~clk;

  task automatic set0(input logic v, input int a, input int b,
                      input logic c, input logic l);
    req0_valid = v;
    req0_a     = 5'(a);
    req0_b     = 5'(b);
    req0_cin   = c;
    req0_last  = l;
  endtask

  task automatic set1(input logic v, input int a, input int b,
                      input logic c, input logic l);
    req1_valid = v;
    req1_a     = 5'(a);
    req1_b     = 5'(b);
    req1_cin   = c;
    req1_last  = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set0(1, 3, 3, 0, 1);
    set1(1, 3, 3, 0, 1);
    #1;
    checks++;
    if (rv !== 9'h000) begin
      errors++;
      $display("FAIL reset_res got %h want 000", rv);
    end
    checks++;
    if ({rdy, lock_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready got %b want 000", {rdy, lock_err});
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set0(1, 7, 9, 0, 1);
    @(negedge clk);
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL single_rdy got %b want 10", rdy);
    end
    tick();
    set0(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rv !== {1'b1, 1'b0, 1'b1, 1'b0, 5'd16}) begin
      errors++;
      $display("FAIL single_res got %h want %h", rv,
               {1'b1, 1'b0, 1'b1, 1'b0, 5'd16});
    end
    tick();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got %b want 0", res_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e;
    do_reset();
    set0(1, 1, 2, 0, 1);
    set1(1, 3, 4, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rdy !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL b2b_rdy%0d got %b", i, rdy);
      end
      if (i > 0) begin
        e = (i % 2 == 1) ? {4'b1010, 5'd3} : {4'b1110, 5'd7};
        checks++;
        if (rv !== e) begin
          errors++;
          $display("FAIL b2b_res%0d got %h want %h", i, rv, e);
        end
      end
      tick();
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rv !== {4'b1110, 5'd7}) begin
      errors++;
      $display("FAIL b2b_tail got %h want %h", rv, {4'b1110, 5'd7});
    end
    tick();
  endtask

  task automatic test_lock_chain();
    logic [4:0] es;
`ifdef CARRY_CHAIN_EN
    es = 5'd1;
`else
    es = 5'd0;
`endif
    do_reset();
    set1(1, 31, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (rdy !== 2'b01) begin
      errors++;
      $display("FAIL lock_b0_rdy got %b want 01", rdy);
    end
    tick();
    set1(0, 0, 0, 0, 0);
    set0(1, 5, 5, 0, 1);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL lock_hold got %b want 0", req0_ready);
    end
    checks++;
    if (rv !== {4'b1101, 5'd0}) begin
      errors++;
      $display("FAIL lock_b0_res got %h want %h", rv, {4'b1101, 5'd0});
    end
    tick();
    set1(1, 0, 0, 0, 1);
    @(negedge clk);
    checks++;
    if ({rdy, res_valid} !== 3'b010) begin
      errors++;
      $display("FAIL lock_b1_rdy got %b want 010", {rdy, res_valid});
    end
    tick();
    set1(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL lock_rel_rdy got %b want 10", rdy);
    end
    checks++;
    if (rv !== {4'b1110, es}) begin
      errors++;
      $display("FAIL lock_b1_res got %h want %h", rv, {4'b1110, es});
    end
    tick();
    set0(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rv !== {4'b1010, 5'd10}) begin
      errors++;
      $display("FAIL lock_next got %h want %h", rv, {4'b1010, 5'd10});
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set0(1, 2, 3, 0, 1);
    @(negedge clk);
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL bp_first_rdy got %b want 10", rdy);
    end
    tick();
    res_ready = 1'b0;
    set0(1, 4, 4, 0, 1);
    set1(1, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rdy, rv} !== {2'b00, 4'b1010, 5'd5}) begin
        errors++;
        $display("FAIL bp_hold%0d got %h want %h", i, {rdy, rv},
                 {2'b00, 4'b1010, 5'd5});
      end
      tick();
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy, rv} !== {2'b01, 4'b1010, 5'd5}) begin
      errors++;
      $display("FAIL bp_release got %h want %h", {rdy, rv},
               {2'b01, 4'b1010, 5'd5});
    end
    tick();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rv !== {4'b1110, 5'd2}) begin
      errors++;
      $display("FAIL bp_swap got %h want %h", rv, {4'b1110, 5'd2});
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    set1(1, 6, 6, 0, 1);
    for (int i = 0; i < 8; i++) begin
      set0(1, i, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (rdy !== 2'b10) begin
        errors++;
        $display("FAIL to_rdy%0d got %b want 10", i, rdy);
      end
      if (i > 0) begin
        checks++;
        if ({lock_err, rv} !== {1'b0, 4'b1000, 5'(i - 1)}) begin
          errors++;
          $display("FAIL to_res%0d got %h", i, {lock_err, rv});
        end
      end
      tick();
    end
    set0(1, 9, 9, 0, 0);
    @(negedge clk);
    checks++;
    if ({lock_err, rv} !== {1'b1, 4'b1010, 5'd7}) begin
      errors++;
      $display("FAIL to_forced got %h want %h", {lock_err, rv},
               {1'b1, 4'b1010, 5'd7});
    end
    checks++;
    if (rdy !== 2'b01) begin
      errors++;
      $display("FAIL to_handoff got %b want 01", rdy);
    end
    tick();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({lock_err, rv} !== {1'b0, 4'b1110, 5'd12}) begin
      errors++;
      $display("FAIL to_after got %h want %h", {lock_err, rv},
               {1'b0, 4'b1110, 5'd12});
    end
    tick();
  endtask

  task automatic test_reset_locked();
    do_reset();
    set1(1, 31, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (rdy !== 2'b01) begin
      errors++;
      $display("FAIL rl_rdy got %b want 01", rdy);
    end
    tick();
    set1(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL rl_pre got %b want 1", res_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rv !== 9'h000) begin
      errors++;
      $display("FAIL rl_async got %h want 000", rv);
    end
    #1;
    rst_n = 1'b1;
    tick();
    set0(1, 1, 1, 0, 1);
    set1(1, 3, 3, 0, 1);
    @(negedge clk);
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL rl_winner got %b want 10", rdy);
    end
    tick();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rv !== {4'b1010, 5'd2}) begin
      errors++;
      $display("FAIL rl_res got %h want %h", rv, {4'b1010, 5'd2});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lock_chain();
    test_backpressure();
    test_timeout();
    test_reset_locked();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
